// File: rtl/fp_adder_pkg.sv
// Shared widths, operand field helpers and stage payload layouts for the pipelined FP adder.
package fp_adder_pkg;

    localparam int EXP_W_DEF = 2;
    localparam int MAN_W_DEF = 4;
    localparam int W = EXP_W_DEF + MAN_W_DEF;

    // Payload layouts at the default widths; the top declares the same layout against its own parameters.
    typedef struct packed {
        logic [EXP_W_DEF-1:0] exp_big;
        logic [MAN_W_DEF-1:0] man_big;
        logic [MAN_W_DEF-1:0] man_small;
        logic [EXP_W_DEF-1:0] d;
    } s1_t;

    typedef struct packed {
        logic [EXP_W_DEF-1:0] exp_big;
        logic [MAN_W_DEF:0]   sum;
        logic                 guard;
        logic                 sticky;
    } s2_t;

    function automatic logic [EXP_W_DEF-1:0] fp_exp(input logic [W-1:0] op);
        return op[W-1:MAN_W_DEF];
    endfunction

    function automatic logic [MAN_W_DEF-1:0] fp_man(input logic [W-1:0] op);
        return op[MAN_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right-aligns the smaller mantissa by d, reporting the first discarded bit (guard) and the OR of the rest (sticky).
module fp_align_shifter
    import fp_adder_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic [MAN_W-1:0] man,
    input  logic [EXP_W-1:0] d,
    output logic [MAN_W-1:0] aligned,
    output logic             guard,
    output logic             sticky
);

    always_comb begin
        aligned = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        if (int'(d) < MAN_W) begin
            aligned = man >> d;
        end
        // Bit i lands one place below the LSB when d == i+1, further below otherwise.
        for (int i = 0; i < MAN_W; i++) begin
            if (int'(d) == i + 1) begin
                guard = man[i];
            end else if (int'(d) > i + 1) begin
                sticky = sticky | man[i];
            end
        end
    end

endmodule

// File: rtl/fp_adder_pipe.sv
// 3-stage unsigned FP adder with valid/ready, exponent saturation and inexact flag.
// Define FP_ADDER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_adder_pipe
    import fp_adder_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_a,
    input  logic [EXP_W+MAN_W-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_sum,
    output logic                   out_ovf,
    output logic                   out_inexact
);

    localparam int OP_W = EXP_W + MAN_W;

    typedef struct packed {
        logic [EXP_W-1:0] exp_big;
        logic [MAN_W-1:0] man_big;
        logic [MAN_W-1:0] man_small;
        logic [EXP_W-1:0] d;
    } st1_t;

    typedef struct packed {
        logic [EXP_W-1:0] exp_big;
        logic [MAN_W:0]   sum;
        logic             guard;
        logic             sticky;
    } st2_t;

    logic en;
    logic v1, v2;
    st1_t s1_d, s1_q;
    st2_t s2_d, s2_q;

    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             swap;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign exp_a = in_a[OP_W-1:MAN_W];
    assign exp_b = in_b[OP_W-1:MAN_W];
    assign man_a = in_a[MAN_W-1:0];
    assign man_b = in_b[MAN_W-1:0];

    // A zero mantissa is always the small side so the other operand passes through with its exponent intact.
    assign swap = (man_b != '0) && ((man_a == '0) || (exp_b > exp_a));

    always_comb begin
        s1_d = '0;
        if (swap) begin
            s1_d.exp_big   = exp_b;
            s1_d.man_big   = man_b;
            s1_d.man_small = man_a;
            s1_d.d         = exp_b - exp_a;
        end else begin
            s1_d.exp_big   = exp_a;
            s1_d.man_big   = man_a;
            s1_d.man_small = man_b;
            s1_d.d         = exp_a - exp_b;
        end
    end

    logic [MAN_W-1:0] aligned;
    logic             al_guard, al_sticky;

    fp_align_shifter #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_align (
        .man     (s1_q.man_small),
        .d       (s1_q.d),
        .aligned (aligned),
        .guard   (al_guard),
        .sticky  (al_sticky)
    );

    always_comb begin
        s2_d.exp_big = s1_q.exp_big;
        s2_d.sum     = {1'b0, s1_q.man_big} + {1'b0, aligned};
        s2_d.guard   = al_guard;
        s2_d.sticky  = al_sticky;
    end

    logic             carry, g_n, st_n;
    logic [MAN_W-1:0] man_n, man_r;
    logic [EXP_W+1:0] exp_n;
    logic             ovf_n;
    logic [OP_W-1:0]  sum_n;
`ifdef FP_ADDER_ROUND_NEAREST_EN
    logic             rnd_inc, rnd_carry;
`endif

    always_comb begin
        carry = s2_q.sum[MAN_W];
        if (carry) begin
            man_n = s2_q.sum[MAN_W:1];
            g_n   = s2_q.sum[0];
            st_n  = s2_q.guard | s2_q.sticky;
        end else begin
            man_n = s2_q.sum[MAN_W-1:0];
            g_n   = s2_q.guard;
            st_n  = s2_q.sticky;
        end
        // Two spare exponent bits catch both the normalise and the rounding carry before saturation.
        exp_n = {2'b00, s2_q.exp_big} + (EXP_W+2)'(carry);
`ifdef FP_ADDER_ROUND_NEAREST_EN
        rnd_inc = g_n && (st_n || man_n[0]);
        {rnd_carry, man_r} = {1'b0, man_n} + (MAN_W+1)'(rnd_inc);
        if (rnd_carry) begin
            man_r = {1'b1, {(MAN_W-1){1'b0}}};
            exp_n = exp_n + (EXP_W+2)'(1);
        end
`else
        man_r = man_n;
`endif
        ovf_n = |exp_n[EXP_W+1:EXP_W];
        sum_n = ovf_n ? '1 : {exp_n[EXP_W-1:0], man_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid   <= 1'b0;
            out_sum     <= '0;
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            s1_q      <= s1_d;
            v2        <= v1;
            s2_q      <= s2_d;
            out_valid <= v2;
            if (v2) begin
                out_sum     <= sum_n;
                out_ovf     <= ovf_n;
                out_inexact <= g_n | st_n;
            end
        end
    end

endmodule
